// File: rtl/switch_port_if.sv
// Bundle of the switch_port line and fabric signals: the switch_port drives the
// master side, the fabric/EndDevice environment drives the slave side.
interface switch_port_if #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  rx_in;
  logic [DEPTH-1:0]      in_frame;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_src;
  logic                  rx_err;
  logic                  rx_drop;
  logic [DEPTH-1:0]      eg_frame;
  logic                  eg_valid;
  logic                  eg_ready;
  logic                  tx_out;
  logic                  tx_busy;

  modport master (
    input  rx_in, in_ready, eg_frame, eg_valid,
    output in_frame, in_valid, in_src, rx_err, rx_drop, eg_ready, tx_out, tx_busy
  );

  modport slave (
    output rx_in, in_ready, eg_frame, eg_valid,
    input  in_frame, in_valid, in_src, rx_err, rx_drop, eg_ready, tx_out, tx_busy
  );
endinterface

// File: rtl/switch_port.sv
// Per-port serial line interface: ingress deserializer with SFD check and a
// 2-entry FWFT FIFO toward the fabric; egress serializer with inter-frame gap.
module switch_port #(
  parameter int         DEPTH      = 16,
  parameter int         ADDR_WIDTH = 4,
  parameter logic [3:0] SFD        = 4'b0101,
  parameter int         IFG        = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  switch_port_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;

  typedef enum logic [1:0] {R_IDLE, R_SHIFT, R_CHECK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SHIFT, T_GAP}   tx_state_t;

  // ingress state
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [DEPTH-1:0] rx_shift;
  logic             rx_d1;
  logic             rx_err_q;
  logic             rx_drop_q;
  logic             rx_start;
  logic             sfd_ok;

  // ingress FIFO
  logic [DEPTH-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_cnt;
  logic             push;
  logic             pop;

  // egress state
  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [DEPTH-1:0] tx_shift;
  logic             tx_out_q;
  logic             eg_ready_q;
  logic             tx_busy_q;
  logic             eg_hs;

  assign rx_start = (rx_state == R_IDLE) && rx_d1 && !bus.rx_in;
  assign sfd_ok   = (rx_shift[DEPTH-1 -: 4] == SFD);
  assign pop      = (fifo_cnt != 2'd0) && bus.in_ready;
  // A full FIFO still accepts when the fabric frees a slot on the same edge.
  assign push     = (rx_state == R_CHECK) && sfd_ok && ((fifo_cnt != 2'd2) || pop);
  assign eg_hs    = eg_ready_q && bus.eg_valid;

  // ---- ingress: deserializer ----
  always_ff @(posedge clk) begin
    if (rx_start || (rx_state == R_SHIFT))
      rx_shift <= {rx_shift[DEPTH-2:0], bus.rx_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= R_IDLE;
      rx_cnt    <= '0;
      rx_d1     <= 1'b1;
      rx_err_q  <= 1'b0;
      rx_drop_q <= 1'b0;
    end else begin
      rx_d1     <= bus.rx_in;
      rx_err_q  <= 1'b0;
      rx_drop_q <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_start) begin
            rx_cnt   <= CNT_W'(DEPTH - 1);
            rx_state <= R_SHIFT;
          end
        end
        R_SHIFT: begin
          rx_cnt <= rx_cnt - 1'b1;
          if (rx_cnt == CNT_W'(1))
            rx_state <= R_CHECK;
        end
        R_CHECK: begin
          if (!sfd_ok)
            rx_err_q <= 1'b1;
          else if (!push)
            rx_drop_q <= 1'b1;
          rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // ---- ingress: FIFO toward fabric ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rx_shift;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign bus.in_valid = (fifo_cnt != 2'd0);
  assign bus.in_frame = fifo_mem[rd_ptr];
  assign bus.in_src   = fifo_mem[rd_ptr][2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign bus.rx_err   = rx_err_q;
  assign bus.rx_drop  = rx_drop_q;

  // ---- egress: serializer ----
  // The MSB goes straight to tx_out at the handshake, so the shift register
  // holds the remaining bits already aligned to its MSB.
  always_ff @(posedge clk) begin
    if (eg_hs)
      tx_shift <= {bus.eg_frame[DEPTH-2:0], 1'b0};
    else if (tx_state == T_SHIFT)
      tx_shift <= {tx_shift[DEPTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= T_IDLE;
      tx_cnt     <= '0;
      gap_cnt    <= '0;
      tx_out_q   <= 1'b1;
      eg_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (eg_hs) begin
            tx_out_q   <= bus.eg_frame[DEPTH-1];
            tx_cnt     <= CNT_W'(DEPTH - 1);
            eg_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state   <= T_SHIFT;
          end
        end
        T_SHIFT: begin
          if (tx_cnt == '0) begin
            tx_out_q <= 1'b1;
            if (IFG == 1) begin
              eg_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
              tx_state   <= T_IDLE;
            end else begin
              gap_cnt  <= GAP_W'(IFG - 1);
              tx_state <= T_GAP;
            end
          end else begin
            tx_out_q <= tx_shift[DEPTH-1];
            tx_cnt   <= tx_cnt - 1'b1;
          end
        end
        T_GAP: begin
          // Ready rises as the counter reaches zero so the next handshake
          // lands right after the last idle cycle.
          if (gap_cnt <= GAP_W'(1)) begin
            eg_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_state   <= T_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  assign bus.eg_ready = eg_ready_q;
  assign bus.tx_out   = tx_out_q;
  assign bus.tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_switch_port.sv
// Scoreboard bench for switch_port: frame-level reference model feeding
// expectation queues, independent monitor comparing on every negedge.
module tb_switch_port;

  localparam int         DEPTH = 16;
  localparam int         AW    = 4;
  localparam logic [3:0] SFD_G = 4'b0101;
  localparam int         IFG   = 2;

  logic clk = 1'b0;
  logic rst_n;

  switch_port_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

  switch_port #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .SFD(SFD_G), .IFG(IFG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    int          e16;
  } pend_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          occ   = 0;
  logic        err_exp  = 1'b0;
  logic        drop_exp = 1'b0;
  pend_t       pend_q[$];
  logic [15:0] exp_in[$];
  logic        exp_tx[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: frame queue occupancy and the expected egress line bits.
  always @(posedge clk) begin
    logic [15:0] f;
    logic        pop_m;
    logic        push_m;
    cyc++;
    err_exp  = 1'b0;
    drop_exp = 1'b0;
    if (!rst_n) begin
      occ = 0;
      pend_q.delete();
      exp_in.delete();
      exp_tx.delete();
    end else begin
      pop_m  = (occ > 0) && bus.in_ready;
      push_m = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].e16 == cyc) begin
        f = pend_q[0].frame;
        void'(pend_q.pop_front());
        if (f[15:12] != SFD_G) err_exp = 1'b1;
        else if (occ < 2 || pop_m) begin
          push_m = 1'b1;
          exp_in.push_back(f);
        end else drop_exp = 1'b1;
      end
      occ = occ + int'(push_m) - int'(pop_m);
      if (exp_tx.size() == 0 && bus.eg_valid) begin
        for (int i = 15; i >= 0; i--) exp_tx.push_back(bus.eg_frame[i]);
        repeat (IFG) exp_tx.push_back(1'b1);
      end
    end
  end

  // Monitor
  logic [15:0] mon_f;
  logic        mon_b;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_valid", 32'(bus.in_valid), 32'(exp_in.size() != 0));
      if (bus.in_valid && bus.in_ready) begin
        if (exp_in.size() == 0) begin
          total++;
          bad++;
          $display("FAIL in_pop got=%0h exp=none t=%0t", bus.in_frame, $time);
        end else begin
          mon_f = exp_in.pop_front();
          chk("in_frame", 32'(bus.in_frame), 32'(mon_f));
          chk("in_src", 32'(bus.in_src), 32'(mon_f[7:4]));
        end
      end
      chk("rx_err", 32'(bus.rx_err), 32'(err_exp));
      chk("rx_drop", 32'(bus.rx_drop), 32'(drop_exp));
      mon_b = 1'b1;
      if (exp_tx.size() != 0) mon_b = exp_tx.pop_front();
      chk("tx_out", 32'(bus.tx_out), 32'(mon_b));
      chk("eg_ready", 32'(bus.eg_ready), 32'(exp_tx.size() == 0));
      chk("tx_busy", 32'(bus.tx_busy), 32'(exp_tx.size() != 0));
    end
  end

  // All drivers start and end just after a rising edge.
  task automatic send_rx(input logic [15:0] f, input int gap, input bit pulse_rdy);
    pend_t p;
    p.frame = f;
    p.e16   = cyc + 17;
    pend_q.push_back(p);
    for (int i = 15; i >= 0; i--) begin
      bus.rx_in = f[i];
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.rx_in = 1'b1;
        return;
      end
    end
    bus.rx_in = 1'b1;
    if (pulse_rdy) bus.in_ready = 1'b1;
    @(posedge clk); #1;
    if (pulse_rdy) bus.in_ready = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_eg(input logic [15:0] f);
    bit ok = 1'b0;
    int w  = 0;
    bus.eg_frame = f;
    bus.eg_valid = 1'b1;
    while (!ok && w < 100) begin
      @(negedge clk);
      w++;
      if (bus.eg_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bus.eg_valid = 1'b0;
    chk("eg_handshake", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int w = 0;
    bus.in_ready = 1'b1;
    while ((exp_in.size() != 0 || exp_tx.size() != 0) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    idle(3);
    chk(name, 32'(exp_in.size() + exp_tx.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rx_done;
    rst_n        = 1'b0;
    bus.rx_in    = 1'b1;
    bus.in_ready = 1'b0;
    bus.eg_valid = 1'b0;
    bus.eg_frame = '0;
    #12;
    chk("rst_in_valid", 32'(bus.in_valid), 32'd0);
    chk("rst_in_frame", 32'(bus.in_frame), 32'd0);
    chk("rst_in_src", 32'(bus.in_src), 32'd0);
    chk("rst_rx_err", 32'(bus.rx_err), 32'd0);
    chk("rst_rx_drop", 32'(bus.rx_drop), 32'd0);
    chk("rst_tx_out", 32'(bus.tx_out), 32'd1);
    chk("rst_eg_ready", 32'(bus.eg_ready), 32'd1);
    chk("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    // good frame, immediate pop
    bus.in_ready = 1'b1;
    send_rx(16'h5A3C, 1, 1'b0);
    idle(4);
    // bad SFD
    send_rx(16'h7A3C, 1, 1'b0);
    idle(4);
    // overflow: third frame dropped, first two kept in order
    bus.in_ready = 1'b0;
    send_rx(16'h5111, 1, 1'b0);
    send_rx(16'h5222, 1, 1'b0);
    send_rx(16'h5333, 1, 1'b0);
    idle(3);
    drain("drain_overflow");
    bus.in_ready = 1'b0;

    // egress serialization with a back-to-back held-valid frame
    send_eg(16'h5123);
    send_eg(16'h5FFF);
    drain("drain_egress");
    bus.in_ready = 1'b0;

    // full FIFO popped in the same cycle a third frame is checked, egress busy
    fork
      begin
        send_rx(16'h5111, 1, 1'b0);
        send_rx(16'h5222, 1, 1'b0);
        send_rx(16'h5444, 1, 1'b1);
      end
      begin
        idle(20);
        send_eg(16'h5ABC);
      end
    join
    chk("dup_occ_full", 32'(bus.in_valid), 32'd1);
    drain("drain_duplex");

    // reset in the middle of both directions
    bus.in_ready = 1'b0;
    fork
      send_eg(16'h5123);
      begin
        idle(3);
        send_rx(16'h5A3C, 1, 1'b0);
      end
      begin
        idle(11);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx_out", 32'(bus.tx_out), 32'd1);
        chk("rst_mid_in_valid", 32'(bus.in_valid), 32'd0);
        idle(3);
        rst_n = 1'b1;
      end
    join
    idle(2);
    bus.in_ready = 1'b1;
    send_rx(16'h5A3C, 1, 1'b0);
    idle(30);
    drain("drain_after_reset");

    // randomized full-duplex traffic
    rx_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [31:0] r;
          logic [15:0] f;
          r = $urandom;
          f = r[15:0];
          f[15] = 1'b0;
          if ($urandom_range(0, 3) != 0) f[15:12] = SFD_G;
          send_rx(f, $urandom_range(1, 3), 1'b0);
        end
        rx_done = 1'b1;
      end
      begin
        while (!rx_done) begin
          bus.in_ready = ($urandom_range(0, 2) == 0);
          @(posedge clk); #1;
        end
      end
      begin
        for (int n = 0; n < 20; n++) begin
          logic [31:0] r;
          r = $urandom;
          idle($urandom_range(0, 5));
          send_eg(r[15:0]);
        end
      end
    join
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
